dataflow_deadlock_monitor: RTL

Parametrised simulation/debug monitor for dataflow regions with any number of concurrent processes. Each process reports whether it is blocked and which peer processes it is waiting on. The block waits until that wait-for graph has been stable for a programmable settle period. It then runs a bounded forward/backward reachability probe to detect a wait cycle, and latches a sticky report with the origin process and the full cycle membership mask. It sits beside the dataflow top level and generalises the fixed two-process detector to N processes with cycle localisation.

---
 rtl/dl_monitor_pkg.sv | 24 ++
 rtl/dl_reach_step.sv | 21 ++
 rtl/dataflow_deadlock_monitor.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/dl_monitor_pkg.sv
// Shared types and sizing helpers for the dataflow deadlock monitor.
// Imported by the top level and the reachability step.
package dl_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    PROBE,
    REPORT
  } dl_state_e;

  localparam int DEFAULT_STABLE_CYCLES = 16;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

  // Settle counter width: $clog2(stable_cycles + 1).
  function automatic int cnt_width(input int stable_cycles);
    return clog2_min1(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/dl_reach_step.sv
// One hop of set reachability over an N x N adjacency matrix:
// next_set = cur_set | (union of row[k] for every k in cur_set).
module dl_reach_step #(
  parameter int N_PROC = 4
) (
  input  logic [N_PROC-1:0]        cur_set,
  input  logic [N_PROC*N_PROC-1:0] matrix,
  output logic [N_PROC-1:0]        next_set
);

  // NOTE: next_set gets its full default first, so no path leaves it unassigned (no latch).
  always_comb begin
    next_set = cur_set;
    for (int k = 0; k < N_PROC; k++) begin
      for (int j = 0; j < N_PROC; j++) begin
        if (cur_set[k] && matrix[k*N_PROC + j]) next_set[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dataflow_deadlock_monitor.sv
// Wait-for graph deadlock monitor: waits for a stable graph, probes one origin
// at a time for a wait cycle, and latches a sticky report with the cycle members.
module dataflow_deadlock_monitor
  import dl_monitor_pkg::*;
#(
  parameter int N_PROC        = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int IDX_W         = clog2_min1(N_PROC)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [N_PROC-1:0]        proc_blocked,
  input  logic [N_PROC*N_PROC-1:0] wait_for,
  input  logic                     clear,
  output logic                     dl_detect,
  output logic [IDX_W-1:0]         dl_origin,
  output logic [N_PROC-1:0]        dl_cycle_mask,
  output logic                     probe_busy
);

  localparam int NN    = N_PROC * N_PROC;
  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_PROC - 1);

  dl_state_e         state, state_next;
  logic [NN-1:0]     snapshot, snapshot_next, snapshot_t, live;
  logic [CNT_W-1:0]  settle_cnt, settle_cnt_next;
  logic [IDX_W-1:0]  probe_cnt, probe_cnt_next;
  logic [IDX_W-1:0]  rr_ptr, rr_ptr_next;
  logic [IDX_W-1:0]  origin, origin_next, pick_origin;
  logic [N_PROC-1:0] fwd_set, fwd_set_next, fwd_step;
  logic [N_PROC-1:0] bwd_set, bwd_set_next, bwd_step;
  logic [N_PROC-1:0] pick_row, pick_col;
  logic [N_PROC-1:0] rpt_mask, rpt_mask_next;
  logic              graph_changed;

  // An edge is live only when both ends are stalled; self edges count.
  always_comb begin
    live = '0;
    snapshot_t = '0;
    for (int i = 0; i < N_PROC; i++) begin
      for (int j = 0; j < N_PROC; j++) begin
        live[i*N_PROC + j]       = proc_blocked[i] & wait_for[i*N_PROC + j] & proc_blocked[j];
        snapshot_t[j*N_PROC + i] = snapshot[i*N_PROC + j];
      end
    end
  end

  assign graph_changed = (live != snapshot);

  // Lowest blocked index at or above rr_ptr, else lowest blocked overall.
  always_comb begin
    pick_origin = '0;
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (proc_blocked[i]) pick_origin = IDX_W'(i);
    end
    for (int i = N_PROC - 1; i >= 0; i--) begin
      if (proc_blocked[i] && (i >= int'(rr_ptr))) pick_origin = IDX_W'(i);
    end
  end

  always_comb begin
    pick_row = '0;
    pick_col = '0;
    for (int k = 0; k < N_PROC; k++) begin
      pick_row[k] = snapshot[int'(pick_origin)*N_PROC + k];
      pick_col[k] = snapshot[k*N_PROC + int'(pick_origin)];
    end
  end

  dl_reach_step #(.N_PROC(N_PROC)) u_fwd_step (
    .cur_set  (fwd_set),
    .matrix   (snapshot),
    .next_set (fwd_step)
  );

  dl_reach_step #(.N_PROC(N_PROC)) u_bwd_step (
    .cur_set  (bwd_set),
    .matrix   (snapshot_t),
    .next_set (bwd_step)
  );

  always_comb begin
    state_next      = state;
    snapshot_next   = snapshot;
    settle_cnt_next = settle_cnt;
    probe_cnt_next  = probe_cnt;
    rr_ptr_next     = rr_ptr;
    origin_next     = origin;
    fwd_set_next    = fwd_set;
    bwd_set_next    = bwd_set;
    rpt_mask_next   = rpt_mask;
    unique case (state)
      IDLE: begin
        if (enable && (|proc_blocked)) begin
          snapshot_next   = live;
          settle_cnt_next = '0;
          state_next      = SETTLE;
        end
      end
      SETTLE: begin
        if (!enable || !(|proc_blocked)) begin
          state_next = IDLE;
        end else if (graph_changed) begin
          snapshot_next   = live;
          settle_cnt_next = '0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_next     = PROBE;
          origin_next    = pick_origin;
          fwd_set_next   = pick_row;
          bwd_set_next   = pick_col;
          probe_cnt_next = '0;
        end else begin
          settle_cnt_next = settle_cnt + CNT_W'(1);
        end
      end
      PROBE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (graph_changed) begin
          // Abort: resettle on the new graph, same candidate next time.
          snapshot_next   = live;
          settle_cnt_next = '0;
          state_next      = SETTLE;
        end else begin
          fwd_set_next = fwd_step;
          bwd_set_next = bwd_step;
          if (probe_cnt == LAST_IDX) begin
            settle_cnt_next = '0;
            if (fwd_step[origin]) begin
              rpt_mask_next = fwd_step & bwd_step;
              state_next    = REPORT;
            end else begin
              rr_ptr_next = (origin == LAST_IDX) ? '0 : origin + IDX_W'(1);
              state_next  = SETTLE;
            end
          end else begin
            probe_cnt_next = probe_cnt + IDX_W'(1);
          end
        end
      end
      REPORT: begin
        if (clear) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      snapshot      <= '0;
      settle_cnt    <= '0;
      probe_cnt     <= '0;
      rr_ptr        <= '0;
      origin        <= '0;
      fwd_set       <= '0;
      bwd_set       <= '0;
      rpt_mask      <= '0;
      dl_detect     <= 1'b0;
      dl_origin     <= '0;
      dl_cycle_mask <= '0;
      probe_busy    <= 1'b0;
    end else begin
      state      <= state_next;
      snapshot   <= snapshot_next;
      settle_cnt <= settle_cnt_next;
      probe_cnt  <= probe_cnt_next;
      rr_ptr     <= rr_ptr_next;
      origin     <= origin_next;
      fwd_set    <= fwd_set_next;
      bwd_set    <= bwd_set_next;
      rpt_mask   <= rpt_mask_next;
      probe_busy <= (state == PROBE);
      // Report outputs trail the state by one edge and are frozen outside REPORT.
      if (state == REPORT) begin
        if (clear) begin
          dl_detect     <= 1'b0;
          dl_origin     <= '0;
          dl_cycle_mask <= '0;
        end else begin
          dl_detect     <= 1'b1;
          dl_origin     <= origin;
          dl_cycle_mask <= rpt_mask;
        end
      end
    end
  end

endmodule
